// File: rtl/pragmatic_pkg.sv
// rtl/pragmatic_pkg.sv - state encoding and width helpers shared by pragmatic_serial_mac
package pragmatic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int shift_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

  function automatic int term_width(input int data_width, input int s1_bits);
    return data_width + 1 + (1 << s1_bits) - 1;
  endfunction

  function automatic int tree_width(input int data_width, input int s1_bits, input int vec_length);
    return term_width(data_width, s1_bits) + $clog2(vec_length);
  endfunction

endpackage

// File: rtl/pragmatic_lane_sel.sv
// rtl/pragmatic_lane_sel.sv - per-lane essential-bit selector: lowest set bit, window test, mask update
module pragmatic_lane_sel
  import pragmatic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int S1_BITS    = 2
) (
  input  logic [DATA_WIDTH-1:0]              mask,
  input  logic [shift_width(DATA_WIDTH)-1:0] base,
  output logic                               participate,
  output logic [S1_BITS-1:0]                 offset,
  output logic [DATA_WIDTH-1:0]              mask_nxt,
  output logic [DATA_WIDTH-1:0]              lsb_onehot
);

  localparam int BASE_W = shift_width(DATA_WIDTH);

  logic [BASE_W-1:0] pos;
  logic [BASE_W-1:0] diff;
  logic              found;

  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        pos   = BASE_W'(i);
        found = 1'b1;
      end
    end
    // base is the global lowest bit, so pos >= base whenever found
    diff        = pos - base;
    participate = found && (int'(diff) < (1 << S1_BITS));
    offset      = S1_BITS'(diff);
    mask_nxt    = mask;
    if (participate) mask_nxt[pos] = 1'b0;
    lsb_onehot = '0;
    if (found) lsb_onehot[pos] = 1'b1;
  end

endmodule

// File: rtl/pragmatic_serial_mac.sv
// rtl/pragmatic_serial_mac.sv - essential-bit serial MAC over signed vectors; PRAGMATIC_SERIAL_MAC_SAT_EN clamps result
module pragmatic_serial_mac
  import pragmatic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 8,
  parameter int S1_BITS      = 2,
  parameter int ACC_WIDTH    = 32,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_first,
  input  logic                                in_last,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]    act,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]    wgt,
  input  logic signed [ACC_WIDTH-1:0]         acc_init,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [RESULT_WIDTH-1:0]      result,
  output logic                                busy
);

  localparam int BASE_W = shift_width(DATA_WIDTH);
  localparam int TERM_W = term_width(DATA_WIDTH, S1_BITS);
  localparam int TREE_W = tree_width(DATA_WIDTH, S1_BITS, VEC_LENGTH);

  state_t                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       act_q  [VEC_LENGTH];
  logic [DATA_WIDTH-1:0]       act_d  [VEC_LENGTH];
  logic [DATA_WIDTH-1:0]       mask_q [VEC_LENGTH];
  logic [DATA_WIDTH-1:0]       mask_d [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]       neg_q, neg_d;
  logic                        last_q, last_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] psum_reg_q, psum_reg_d;

  logic [DATA_WIDTH-1:0]       mask_nxt [VEC_LENGTH];
  logic [DATA_WIDTH-1:0]       lsb_oh   [VEC_LENGTH];
  logic [S1_BITS-1:0]          offset   [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]       part;
  logic [DATA_WIDTH-1:0]       lsb_any;
  logic [BASE_W-1:0]           base;
  logic signed [DATA_WIDTH:0]  a_ext;
  logic signed [TERM_W-1:0]    term;
  logic signed [TREE_W-1:0]    tree_sum;
  logic signed [ACC_WIDTH-1:0] psum;
  logic                        masks_done;
  logic [DATA_WIDTH-1:0]       wgt_lane;
  logic signed [RESULT_WIDTH-1:0] res_val;

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    pragmatic_lane_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .S1_BITS    (S1_BITS)
    ) u_sel (
      .mask        (mask_q[j]),
      .base        (base),
      .participate (part[j]),
      .offset      (offset[j]),
      .mask_nxt    (mask_nxt[j]),
      .lsb_onehot  (lsb_oh[j])
    );
  end

  always_comb begin : base_sel
    lsb_any = '0;
    for (int j = 0; j < VEC_LENGTH; j++) lsb_any = lsb_any | lsb_oh[j];
    base = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (lsb_any[i]) base = BASE_W'(i);
    end
  end

  // One extra bit holds -(-2**(DATA_WIDTH-1)) without overflow
  always_comb begin : adder_tree
    tree_sum   = '0;
    masks_done = 1'b1;
    a_ext      = '0;
    term       = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      a_ext = {act_q[j][DATA_WIDTH-1], act_q[j]};
      if (neg_q[j]) a_ext = -a_ext;
      term = TERM_W'(a_ext) <<< offset[j];
      if (part[j]) tree_sum = tree_sum + TREE_W'(term);
      if (mask_nxt[j] != '0) masks_done = 1'b0;
    end
    psum = ACC_WIDTH'(tree_sum) <<< base;
  end

  always_comb begin : fsm
    state_d    = state_q;
    act_d      = act_q;
    mask_d     = mask_q;
    neg_d      = neg_q;
    last_d     = last_q;
    acc_d      = acc_q;
    psum_reg_d = '0;
    wgt_lane   = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < VEC_LENGTH; j++) begin
            wgt_lane  = wgt[j*DATA_WIDTH +: DATA_WIDTH];
            act_d[j]  = act[j*DATA_WIDTH +: DATA_WIDTH];
            neg_d[j]  = wgt_lane[DATA_WIDTH-1];
            mask_d[j] = wgt_lane[DATA_WIDTH-1] ? -wgt_lane : wgt_lane;
          end
          last_d = in_last;
          if (in_first) acc_d = acc_init;
          state_d = RUN;
        end
      end
      RUN: begin
        mask_d     = mask_nxt;
        psum_reg_d = psum;
        acc_d      = acc_q + psum_reg_q;
        if (masks_done) state_d = DRAIN;
      end
      DRAIN: begin
        acc_d   = acc_q + psum_reg_q;
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      neg_q      <= '0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      psum_reg_q <= '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        act_q[j]  <= '0;
        mask_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      neg_q      <= neg_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      psum_reg_q <= psum_reg_d;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        act_q[j]  <= act_d[j];
        mask_q[j] <= mask_d[j];
      end
    end
  end

`ifdef PRAGMATIC_SERIAL_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ~RES_MAX;

  always_comb begin : result_sel
    if (acc_q > RES_MAX)      res_val = RESULT_WIDTH'(RES_MAX);
    else if (acc_q < RES_MIN) res_val = RESULT_WIDTH'(RES_MIN);
    else                      res_val = acc_q[RESULT_WIDTH-1:0];
  end
`else
  always_comb begin : result_sel
    res_val = acc_q[RESULT_WIDTH-1:0];
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = (state_q == OUT) ? res_val : '0;

endmodule

// File: tb/tb_pragmatic_serial_mac.sv
// tb/tb_pragmatic_serial_mac.sv - randomized self-checking bench for pragmatic_serial_mac
module tb_pragmatic_serial_mac;

  localparam int DW = 8;
  localparam int VL = 8;
  localparam int AW = 32;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [VL*DW-1:0] act = '0, wgt = '0;
  logic signed [AW-1:0] acc_init = '0;
  logic signed [RW-1:0] result;

  int checks = 0;
  int failures = 0;
  int acc_m = 0;
  int last_r = 0;

  always #5 clk = ~clk;

  pragmatic_serial_mac dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .act(act), .wgt(wgt),
    .acc_init(acc_init), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  function automatic int lowest_bit(input int x);
    for (int i = 0; i < 32; i++) if (((x >> i) & 1) != 0) return i;
    return -1;
  endfunction

  // Cycles needed when each cycle retires, per lane, the lowest remaining weight bit within 4 of the global lowest
  function automatic int run_cycles(input int w [VL]);
    int m [VL];
    int r;
    int base;
    int lo;
    bit left;
    r = 0;
    for (int j = 0; j < VL; j++) m[j] = (w[j] < 0 ? -w[j] : w[j]) & 255;
    do begin
      r++;
      base = -1;
      for (int j = 0; j < VL; j++) if (m[j] != 0) begin
        lo = lowest_bit(m[j]);
        if (base < 0 || lo < base) base = lo;
      end
      for (int j = 0; j < VL; j++) if (m[j] != 0) begin
        lo = lowest_bit(m[j]);
        if (lo - base < 4) m[j] = m[j] & ~(1 << lo);
      end
      left = 1'b0;
      for (int j = 0; j < VL; j++) if (m[j] != 0) left = 1'b1;
    end while (left);
    return r;
  endfunction

  function automatic logic [RW-1:0] exp_result(input int acc);
`ifdef PRAGMATIC_SERIAL_MAC_SAT_EN
    if (acc > 32767) return 16'h7fff;
    if (acc < -32768) return 16'h8000;
    return RW'(acc);
`else
    return RW'(acc);
`endif
  endfunction

  task automatic drive_vec(input int a [VL], input int w [VL], input bit first, input bit last, input int init);
    int g;
    g = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%b expected=1", in_ready);
    end
    for (int j = 0; j < VL; j++) begin
      act[j*DW +: DW] = DW'(a[j]);
      wgt[j*DW +: DW] = DW'(w[j]);
    end
    in_first = first;
    in_last  = last;
    acc_init = init;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    if (first) acc_m = init;
    for (int j = 0; j < VL; j++) acc_m = acc_m + a[j] * w[j];
    last_r = run_cycles(w);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (result !== 16'sd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    reset = 1'b1;
    acc_m = 0;
  endtask

  task automatic test_basic();
    int a [VL];
    int w [VL];
    int n;
    for (int j = 0; j < VL; j++) begin a[j] = 3; w[j] = 1; end
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_timeout out_valid=%b exp=1", out_valid); end
    if (n != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", n); end
    if (result !== 16'sd24) begin failures++; $display("FAIL basic_result got=%0d exp=24", result); end
    pop_out();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_return_idle in_ready=%b busy=%b exp=1/0", in_ready, busy);
    end
  endtask

  task automatic test_two_bits();
    int a [VL];
    int w [VL];
    int n;
    for (int j = 0; j < VL; j++) begin a[j] = j + 1; w[j] = 0; end
    a[0] = 5;
    w[0] = 'h11;
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks += 2;
    if (n != 4) begin failures++; $display("FAIL two_bits_latency got=%0d exp=4", n); end
    if (result !== 16'sd85) begin failures++; $display("FAIL two_bits_result got=%0d exp=85", result); end
    pop_out();
  endtask

  task automatic test_neg_extreme();
    int a [VL];
    int w [VL];
    int n;
    for (int j = 0; j < VL; j++) begin a[j] = 9; w[j] = 0; end
    a[0] = -1;
    w[0] = -128;
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks += 2;
    if (n != 3) begin failures++; $display("FAIL neg128_latency got=%0d exp=3", n); end
    if (result !== 16'sd128) begin failures++; $display("FAIL neg128_result got=%0d exp=128", result); end
    pop_out();
    a[1] = 7;
    w[1] = -1;
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks += 2;
    if (n != 4) begin failures++; $display("FAIL neg_mix_latency got=%0d exp=4", n); end
    if (result !== 16'sd121) begin failures++; $display("FAIL neg_mix_result got=%0d exp=121", result); end
    pop_out();
  endtask

  task automatic test_zero_and_multi();
    int a [VL];
    int w [VL];
    int n;
    for (int j = 0; j < VL; j++) begin a[j] = int'($urandom_range(0, 255)) - 128; w[j] = 0; end
    drive_vec(a, w, 1'b1, 1'b1, 100);
    wait_out(n);
    checks += 2;
    if (n != 3) begin failures++; $display("FAIL zero_wgt_latency got=%0d exp=3", n); end
    if (result !== 16'sd100) begin failures++; $display("FAIL zero_wgt_result got=%0d exp=100", result); end
    pop_out();
    for (int j = 0; j < VL; j++) begin a[j] = 3; w[j] = 1; end
    drive_vec(a, w, 1'b1, 1'b0, 0);
    drive_vec(a, w, 1'b0, 1'b0, 0);
    drive_vec(a, w, 1'b0, 1'b1, 0);
    wait_out(n);
    checks += 2;
    if (n != 3) begin failures++; $display("FAIL multi_latency got=%0d exp=3", n); end
    if (result !== 16'sd72) begin failures++; $display("FAIL multi_result got=%0d exp=72", result); end
    pop_out();
  endtask

  task automatic test_backpressure();
    int a [VL];
    int w [VL];
    int n;
    logic signed [RW-1:0] hold;
    for (int j = 0; j < VL; j++) begin a[j] = 3; w[j] = 1; end
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    hold = 16'sd24;
    act = {VL*DW/32{$urandom}};
    wgt = {VL*DW/32{$urandom}};
    in_first = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 3;
      if (result !== hold) begin failures++; $display("FAIL stall_result got=%0d exp=%0d", result, hold); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    pop_out();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
    drive_vec(a, w, 1'b0, 1'b1, 0);
    wait_out(n);
    checks++;
    if (result !== 16'sd48) begin failures++; $display("FAIL continue_result got=%0d exp=48", result); end
    pop_out();
  endtask

  task automatic test_reset_mid_run();
    int a [VL];
    int w [VL];
    int n;
    for (int j = 0; j < VL; j++) begin a[j] = 0; w[j] = 0; end
    a[0] = 5;
    w[0] = 'h11;
    drive_vec(a, w, 1'b1, 1'b1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (result !== 16'sd0) begin failures++; $display("FAIL midrst_result got=%0d exp=0", result); end
    @(negedge clk);
    reset = 1'b1;
    acc_m = 0;
    for (int j = 0; j < VL; j++) begin a[j] = 3; w[j] = 1; end
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks++;
    if (result !== 16'sd24) begin failures++; $display("FAIL post_reset_result got=%0d exp=24", result); end
    pop_out();
  endtask

  task automatic test_saturation();
    int a [VL];
    int w [VL];
    int n;
    logic signed [RW-1:0] exp_v;
    for (int j = 0; j < VL; j++) begin a[j] = 125; w[j] = 40; end
`ifdef PRAGMATIC_SERIAL_MAC_SAT_EN
    exp_v = 16'sd32767;
`else
    exp_v = -16'sd25536;
`endif
    drive_vec(a, w, 1'b1, 1'b1, 0);
    wait_out(n);
    checks++;
    if (result !== exp_v) begin failures++; $display("FAIL sum40000_result got=%0d exp=%0d", result, exp_v); end
    pop_out();
  endtask

  task automatic test_random();
    int a [VL];
    int w [VL];
    int n;
    int nvec;
    for (int t = 0; t < 16; t++) begin
      nvec = int'($urandom_range(1, 3));
      for (int v = 0; v < nvec; v++) begin
        for (int j = 0; j < VL; j++) begin
          a[j] = int'($urandom_range(0, 255)) - 128;
          w[j] = int'($urandom_range(0, 255)) - 128;
          if ($urandom_range(0, 3) == 0) w[j] = 0;
        end
        drive_vec(a, w, v == 0, v == nvec - 1, int'($urandom_range(0, 2000)) - 1000);
      end
      wait_out(n);
      checks += 2;
      if (n != last_r + 2) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", t, n, last_r + 2); end
      if (result !== exp_result(acc_m)) begin
        failures++;
        $display("FAIL rand_result[%0d] got=%0d exp=%0d", t, result, $signed(exp_result(acc_m)));
      end
      pop_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_bits();
    test_neg_extreme();
    test_zero_and_multi();
    test_backpressure();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
